// File: rtl/led_pwm_fader_if.sv
// Control/status bundle between the LED pattern stage (master) and the PWM fader (slave).
// Carries the fade strobe, enable, per-LED targets and the PWM drive/settled status.
interface led_pwm_fader_if #(
  parameter int N_LEDS = 6
);
  logic              tick;
  logic              enable;
  logic [N_LEDS-1:0] target;
  logic [N_LEDS-1:0] pwm_out;
  logic              settled;

  modport master (
    output tick,
    output enable,
    output target,
    input  pwm_out,
    input  settled
  );

  modport slave (
    input  tick,
    input  enable,
    input  target,
    output pwm_out,
    output settled
  );
endinterface

// File: rtl/led_pwm_fader.sv
// Per-LED PWM driver whose brightness ramps toward an on/off target by a fixed
// step on every fade tick, so chase patterns fade instead of hard-switching.
module led_pwm_fader #(
  parameter int N_LEDS    = 6,
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic             clk,
  input  logic             nrst,
  led_pwm_fader_if.slave   bus
);
  localparam logic [PWM_BITS-1:0] C_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] C_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS:0]   C_STEP = (PWM_BITS+1)'(FADE_STEP);
  localparam logic [PWM_BITS-1:0] C_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  // Saturating one-step move toward the target extreme; sum kept one bit wider so it cannot wrap.
  function automatic logic [PWM_BITS-1:0] fade_next(input logic [PWM_BITS-1:0] level,
                                                    input logic              up);
    logic [PWM_BITS:0] sum;
    sum = {1'b0, level} + C_STEP;
    if (up) begin
      if (sum > {1'b0, C_MAX}) return C_MAX;
      else                     return sum[PWM_BITS-1:0];
    end else begin
      if ({1'b0, level} > C_STEP) return level - C_STEP[PWM_BITS-1:0];
      else                        return C_ZERO;
    end
  endfunction

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_level     [N_LEDS];
  logic [PWM_BITS-1:0] w_level_nxt [N_LEDS];
  logic [N_LEDS-1:0]   w_pwm_nxt;
  logic [N_LEDS-1:0]   w_done;
  logic [N_LEDS-1:0]   r_pwm;
  logic                r_settled;
  logic                w_fade;

  // Next levels, PWM compare and per-channel settled terms from the current levels.
  always_comb begin
    w_fade = bus.tick && bus.enable;
    for (int i = 0; i < N_LEDS; i++) begin
      w_level_nxt[i] = r_level[i];
      w_pwm_nxt[i]   = 1'b0;
      w_done[i]      = 1'b0;
      if (w_fade) begin
        w_level_nxt[i] = fade_next(r_level[i], bus.target[i]);
      end else begin
        w_level_nxt[i] = r_level[i];
      end
      // Full level is a constant high, not MAX/2^PWM_BITS duty.
      if (bus.enable) begin
        w_pwm_nxt[i] = (r_level[i] == C_MAX) || (r_cnt < r_level[i]);
      end else begin
        w_pwm_nxt[i] = 1'b0;
      end
      if (bus.target[i]) begin
        w_done[i] = (r_level[i] == C_MAX);
      end else begin
        w_done[i] = (r_level[i] == C_ZERO);
      end
    end
  end

  // PWM counter, brightness levels and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt     <= C_ZERO;
      r_pwm     <= {N_LEDS{1'b0}};
      r_settled <= 1'b1;
      for (int i = 0; i < N_LEDS; i++) begin
        r_level[i] <= C_ZERO;
      end
    end else begin
      r_cnt     <= r_cnt + C_ONE;
      r_pwm     <= w_pwm_nxt;
      r_settled <= &w_done;
      for (int i = 0; i < N_LEDS; i++) begin
        r_level[i] <= w_level_nxt[i];
      end
    end
  end

  assign bus.pwm_out = r_pwm;
  assign bus.settled = r_settled;
endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: two instances (FADE_STEP 16 and 100) checked every cycle
// against an arithmetic model, plus literal pins on model levels and PWM duty counts.
module tb_led_pwm_fader;
  localparam int N = 6;
  localparam int MAXL = 255;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  led_pwm_fader_if #(.N_LEDS(N)) if_a ();
  led_pwm_fader_if #(.N_LEDS(N)) if_b ();

  led_pwm_fader #(.N_LEDS(N), .PWM_BITS(8), .FADE_STEP(16))  dut_a (.clk(clk), .nrst(nrst), .bus(if_a));
  led_pwm_fader #(.N_LEDS(N), .PWM_BITS(8), .FADE_STEP(100)) dut_b (.clk(clk), .nrst(nrst), .bus(if_b));

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Model state: brightness per channel, PWM phase and the outputs expected after each edge
  int lvl_a [N];
  int lvl_b [N];
  int phase = 0;
  logic [N-1:0] exp_pwm_a = '0;
  logic [N-1:0] exp_pwm_b = '0;
  logic exp_set_a = 1'b1;
  logic exp_set_b = 1'b1;

  function automatic int next_lvl(input int l, input bit up, input int step);
    if (up) return (l + step > MAXL) ? MAXL : l + step;
    else    return (l < step) ? 0 : l - step;
  endfunction

  function automatic logic lit(input int l, input int ph, input bit en);
    if (!en) return 1'b0;
    if (l == MAXL) return 1'b1;
    return (ph < l);
  endfunction

  function automatic logic all_done(input int l [N], input logic [N-1:0] t);
    logic ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (t[i] && l[i] != MAXL) ok = 1'b0;
      if (!t[i] && l[i] != 0)   ok = 1'b0;
    end
    return ok;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase <= 0;
      exp_pwm_a <= '0;
      exp_pwm_b <= '0;
      exp_set_a <= 1'b1;
      exp_set_b <= 1'b1;
      for (int i = 0; i < N; i++) begin
        lvl_a[i] <= 0;
        lvl_b[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        exp_pwm_a[i] <= lit(lvl_a[i], phase, if_a.enable);
        exp_pwm_b[i] <= lit(lvl_b[i], phase, if_b.enable);
        if (if_a.tick && if_a.enable) lvl_a[i] <= next_lvl(lvl_a[i], if_a.target[i], 16);
        if (if_b.tick && if_b.enable) lvl_b[i] <= next_lvl(lvl_b[i], if_b.target[i], 100);
      end
      exp_set_a <= all_done(lvl_a, if_a.target);
      exp_set_b <= all_done(lvl_b, if_b.target);
      phase <= (phase + 1) % 256;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("pwm_a", int'(if_a.pwm_out), int'(exp_pwm_a));
      chk("settled_a", int'(if_a.settled), int'(exp_set_a));
      chk("pwm_b", int'(if_b.pwm_out), int'(exp_pwm_b));
      chk("settled_b", int'(if_b.settled), int'(exp_set_b));
    end
  end

  task automatic do_tick(input int gap);
    repeat (gap) @(posedge clk);
    #2;
    if_a.tick = 1'b1;
    if_b.tick = 1'b1;
    @(posedge clk);
    #2;
    if_a.tick = 1'b0;
    if_b.tick = 1'b0;
  endtask

  task automatic count_hi(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk);
      n += int'(if_a.pwm_out[0]);
    end
  endtask

  int n_hi;

  initial begin
    if_a.tick = 1'b0; if_a.enable = 1'b1; if_a.target = 6'b000001;
    if_b.tick = 1'b0; if_b.enable = 1'b1; if_b.target = 6'b000000;
    #1 nrst = 1'b0;
    checking = 1'b1;
    repeat (3) @(posedge clk);
    chk("reset_pwm_a", int'(if_a.pwm_out), 0);
    chk("reset_settled_a", int'(if_a.settled), 1);
    #2 nrst = 1'b1;

    // Ramp ch0 up with a tick every 100 clocks
    for (int k = 1; k <= 16; k++) begin
      do_tick(100);
      chk("ramp16_lvl", lvl_a[0], (k < 16) ? 16 * k : 255);
      if (k == 16) begin
        @(negedge clk);
        chk("settled_lag0", int'(if_a.settled), 0);
        @(negedge clk);
        chk("settled_lag1", int'(if_a.settled), 1);
      end
    end

    // Back to 0, then hold at 64 and measure duty
    if_a.target = 6'b000000;
    for (int k = 0; k < 16; k++) do_tick(3);
    chk("down_to0", lvl_a[0], 0);
    if_a.target = 6'b000001;
    for (int k = 0; k < 4; k++) do_tick(3);
    chk("hold64_lvl", lvl_a[0], 64);
    repeat (2) @(posedge clk);
    count_hi(n_hi);
    chk("duty64", n_hi, 64);
    for (int k = 0; k < 12; k++) do_tick(3);
    chk("full_lvl", lvl_a[0], 255);
    repeat (2) @(posedge clk);
    count_hi(n_hi);
    chk("duty_full", n_hi, 256);

    // Mid-ramp reversal on the same edge as the tick
    if_a.target = 6'b000000;
    for (int k = 0; k < 16; k++) do_tick(3);
    if_a.target = 6'b000001;
    for (int k = 0; k < 8; k++) do_tick(3);
    chk("rev_128", lvl_a[0], 128);
    repeat (3) @(posedge clk);
    #2;
    if_a.tick = 1'b1; if_b.tick = 1'b1; if_a.target = 6'b000000;
    @(posedge clk);
    #2;
    if_a.tick = 1'b0; if_b.tick = 1'b0;
    chk("rev_112", lvl_a[0], 112);
    for (int k = 0; k < 7; k++) do_tick(3);
    chk("rev_0", lvl_a[0], 0);
    repeat (3) @(posedge clk);

    // Large step on the second instance saturates both ways
    if_b.target = 6'b000001;
    do_tick(3); chk("b_up100", lvl_b[0], 100);
    do_tick(3); chk("b_up200", lvl_b[0], 200);
    do_tick(3); chk("b_up255", lvl_b[0], 255);
    if_b.target = 6'b000000;
    do_tick(3); chk("b_dn155", lvl_b[0], 155);
    do_tick(3); chk("b_dn55", lvl_b[0], 55);
    do_tick(3); chk("b_dn0", lvl_b[0], 0);

    // Enable freezes levels and darkens outputs
    if_a.target = 6'b000001;
    for (int k = 0; k < 5; k++) do_tick(3);
    chk("en_80", lvl_a[0], 80);
    if_a.enable = 1'b0; if_b.enable = 1'b0;
    for (int k = 0; k < 3; k++) do_tick(3);
    chk("en_hold80", lvl_a[0], 80);
    count_hi(n_hi);
    chk("duty_disabled", n_hi, 0);
    @(posedge clk);
    #2;
    if_a.enable = 1'b1; if_b.enable = 1'b1;
    repeat (2) @(posedge clk);
    count_hi(n_hi);
    chk("duty80", n_hi, 80);
    do_tick(3);
    chk("en_96", lvl_a[0], 96);

    // Asynchronous reset between edges mid-fade
    for (int k = 0; k < 4; k++) do_tick(3);
    chk("pre_rst_160", lvl_a[0], 160);
    repeat (20) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    chk("async_pwm", int'(if_a.pwm_out), 0);
    chk("async_settled", int'(if_a.settled), 1);
    @(posedge clk);
    #2 nrst = 1'b1;
    do_tick(3);
    chk("post_rst_16", lvl_a[0], 16);
    repeat (5) @(posedge clk);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
